// File: rtl/id_decode_stage.sv
// ID->EX pipeline stage: instruction class decode, immediate build, load-use interlock.
// Optional macro ID_ILLEGAL_TRAP_EN flags unlisted opcodes as cmd_illegal_ex.
module id_decode_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_id,
    input  logic [31:2] pc_id,
    input  logic        stall,
    input  logic        rst_pipe,
    input  logic        cpu_start,
    output logic [4:0]  rs1_adr_id,
    output logic [4:0]  rs2_adr_id,
    output logic [31:2] pc_ex,
    output logic [31:0] inst_ex,
    output logic [4:0]  rd_adr_ex,
    output logic [31:0] imm_ex,
    output logic        valid_ex,
    output logic        cmd_alu_ex,
    output logic        cmd_ld_ex,
    output logic        cmd_st_ex,
    output logic        cmd_br_ex,
    output logic        cmd_jal_ex,
    output logic        cmd_jalr_ex,
    output logic        cmd_lui_ex,
    output logic        cmd_auipc_ex,
    output logic        cmd_ecall_ex,
    output logic        cmd_mret_ex,
    output logic        cmd_illegal_ex,
    output logic        stall_ld,
    output logic        stall_ld_ex
);

    localparam int unsigned NCMD    = 11;
    localparam int unsigned C_ALU   = 0;
    localparam int unsigned C_LD    = 1;
    localparam int unsigned C_ST    = 2;
    localparam int unsigned C_BR    = 3;
    localparam int unsigned C_JAL   = 4;
    localparam int unsigned C_JALR  = 5;
    localparam int unsigned C_LUI   = 6;
    localparam int unsigned C_AUIPC = 7;
    localparam int unsigned C_ECALL = 8;
    localparam int unsigned C_MRET  = 9;
    localparam int unsigned C_ILL   = 10;

    localparam logic [6:0]  OP_ALU_R  = 7'b0110011;
    localparam logic [6:0]  OP_ALU_I  = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    logic [31:2]     pc_q,   pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [4:0]      rd_q,   rd_d;
    logic [31:0]     imm_q,  imm_d;
    logic            valid_q, valid_d;
    logic [NCMD-1:0] cmd_q,  cmd_d;
    logic            sld_q,  sld_d;

    logic [NCMD-1:0] dec_cmd;
    logic [4:0]      dec_rd;
    logic [31:0]     dec_imm;
    logic            rs1_use, rs2_use;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign rs1_adr_id = inst_id[19:15];
    assign rs2_adr_id = inst_id[24:20];

    assign imm_i = {{20{inst_id[31]}}, inst_id[31:20]};
    assign imm_s = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
    assign imm_b = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
    assign imm_u = {inst_id[31:12], 12'h000};
    assign imm_j = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};

    // Instruction class, destination, immediate and source-register usage
    always_comb begin
        dec_cmd = '0;
        dec_rd  = '0;
        dec_imm = '0;
        rs1_use = 1'b0;
        rs2_use = 1'b0;
        case (inst_id[6:0])
            OP_ALU_R: begin
                dec_cmd[C_ALU] = 1'b1; dec_rd = inst_id[11:7];
                rs1_use = 1'b1; rs2_use = 1'b1;
            end
            OP_ALU_I: begin
                dec_cmd[C_ALU] = 1'b1; dec_rd = inst_id[11:7]; dec_imm = imm_i; rs1_use = 1'b1;
            end
            OP_LOAD: begin
                dec_cmd[C_LD] = 1'b1; dec_rd = inst_id[11:7]; dec_imm = imm_i; rs1_use = 1'b1;
            end
            OP_STORE: begin
                dec_cmd[C_ST] = 1'b1; dec_imm = imm_s; rs1_use = 1'b1; rs2_use = 1'b1;
            end
            OP_BRANCH: begin
                dec_cmd[C_BR] = 1'b1; dec_imm = imm_b; rs1_use = 1'b1; rs2_use = 1'b1;
            end
            OP_JAL: begin
                dec_cmd[C_JAL] = 1'b1; dec_rd = inst_id[11:7]; dec_imm = imm_j;
            end
            OP_JALR: begin
                dec_cmd[C_JALR] = 1'b1; dec_rd = inst_id[11:7]; dec_imm = imm_i; rs1_use = 1'b1;
            end
            OP_LUI: begin
                dec_cmd[C_LUI] = 1'b1; dec_rd = inst_id[11:7]; dec_imm = imm_u;
            end
            OP_AUIPC: begin
                dec_cmd[C_AUIPC] = 1'b1; dec_rd = inst_id[11:7]; dec_imm = imm_u;
            end
            OP_SYSTEM: begin
                if (inst_id == INST_ECALL)     dec_cmd[C_ECALL] = 1'b1;
                else if (inst_id == INST_MRET) dec_cmd[C_MRET]  = 1'b1;
`ifdef ID_ILLEGAL_TRAP_EN
                else                           dec_cmd[C_ILL]   = 1'b1;
`endif
            end
            default: begin
`ifdef ID_ILLEGAL_TRAP_EN
                dec_cmd[C_ILL] = 1'b1;
`endif
            end
        endcase
    end

    // A bubble in EX (valid_q=0) can never raise the interlock, so one hazard costs one bubble
    assign stall_ld = valid_q & cmd_q[C_LD] & (rd_q != 5'd0) &
                      ((rs1_use & (rs1_adr_id == rd_q)) | (rs2_use & (rs2_adr_id == rd_q)));

    // EX register next state: rst_pipe > stall > stall_ld > cpu_start gate > decode
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        valid_d = valid_q;
        cmd_d   = cmd_q;
        sld_d   = sld_q;
        if (rst_pipe) begin
            inst_d = NOP_INST; rd_d = '0; imm_d = '0; valid_d = 1'b0; cmd_d = '0; sld_d = 1'b0;
        end else if (stall) begin
            sld_d = sld_q;
        end else if (stall_ld || !cpu_start) begin
            pc_d = pc_id; inst_d = NOP_INST; rd_d = '0; imm_d = '0; valid_d = 1'b0;
            cmd_d = '0; sld_d = stall_ld;
        end else begin
            pc_d = pc_id; inst_d = inst_id; rd_d = dec_rd; imm_d = dec_imm; valid_d = 1'b1;
            cmd_d = dec_cmd; sld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            rd_q    <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            cmd_q   <= '0;
            sld_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            sld_q   <= sld_d;
        end
    end

    assign pc_ex          = pc_q;
    assign inst_ex        = inst_q;
    assign rd_adr_ex      = rd_q;
    assign imm_ex         = imm_q;
    assign valid_ex       = valid_q;
    assign stall_ld_ex    = sld_q;
    assign cmd_alu_ex     = cmd_q[C_ALU];
    assign cmd_ld_ex      = cmd_q[C_LD];
    assign cmd_st_ex      = cmd_q[C_ST];
    assign cmd_br_ex      = cmd_q[C_BR];
    assign cmd_jal_ex     = cmd_q[C_JAL];
    assign cmd_jalr_ex    = cmd_q[C_JALR];
    assign cmd_lui_ex     = cmd_q[C_LUI];
    assign cmd_auipc_ex   = cmd_q[C_AUIPC];
    assign cmd_ecall_ex   = cmd_q[C_ECALL];
    assign cmd_mret_ex    = cmd_q[C_MRET];
    assign cmd_illegal_ex = cmd_q[C_ILL];

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: decode vector table, hand-written pipeline corner cases,
// then randomized traffic checked against a cycle-level reference model.
module tb_id_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_id;
    logic [31:2] pc_id;
    logic        stall, rst_pipe, cpu_start;
    logic [4:0]  rs1_adr_id, rs2_adr_id;
    logic [31:2] pc_ex;
    logic [31:0] inst_ex;
    logic [4:0]  rd_adr_ex;
    logic [31:0] imm_ex;
    logic        valid_ex;
    logic        cmd_alu_ex, cmd_ld_ex, cmd_st_ex, cmd_br_ex, cmd_jal_ex, cmd_jalr_ex;
    logic        cmd_lui_ex, cmd_auipc_ex, cmd_ecall_ex, cmd_mret_ex, cmd_illegal_ex;
    logic        stall_ld, stall_ld_ex;

    int n_chk  = 0;
    int n_fail = 0;

    id_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id),
        .stall(stall), .rst_pipe(rst_pipe), .cpu_start(cpu_start),
        .rs1_adr_id(rs1_adr_id), .rs2_adr_id(rs2_adr_id),
        .pc_ex(pc_ex), .inst_ex(inst_ex), .rd_adr_ex(rd_adr_ex), .imm_ex(imm_ex),
        .valid_ex(valid_ex),
        .cmd_alu_ex(cmd_alu_ex), .cmd_ld_ex(cmd_ld_ex), .cmd_st_ex(cmd_st_ex),
        .cmd_br_ex(cmd_br_ex), .cmd_jal_ex(cmd_jal_ex), .cmd_jalr_ex(cmd_jalr_ex),
        .cmd_lui_ex(cmd_lui_ex), .cmd_auipc_ex(cmd_auipc_ex), .cmd_ecall_ex(cmd_ecall_ex),
        .cmd_mret_ex(cmd_mret_ex), .cmd_illegal_ex(cmd_illegal_ex),
        .stall_ld(stall_ld), .stall_ld_ex(stall_ld_ex)
    );

    always #5 clk = ~clk;

    // cmd bit order: alu ld st br jal jalr lui auipc ecall mret illegal (alu = bit 0)
    typedef struct packed {
        logic        valid;
        logic [29:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [10:0] cmd;
        logic        sld;
    } ex_t;

    typedef struct {
        logic [31:0] inst;
        logic [29:0] pc;
        logic [10:0] cmd;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] dut_cmd();
        return {cmd_illegal_ex, cmd_mret_ex, cmd_ecall_ex, cmd_auipc_ex, cmd_lui_ex,
                cmd_jalr_ex, cmd_jal_ex, cmd_br_ex, cmd_st_ex, cmd_ld_ex, cmd_alu_ex};
    endfunction

    task automatic check_ex(input string tag, input ex_t e);
        chk({tag, " valid_ex"},    32'(valid_ex),    32'(e.valid));
        chk({tag, " pc_ex"},       32'(pc_ex),       32'(e.pc));
        chk({tag, " inst_ex"},     inst_ex,          e.inst);
        chk({tag, " rd_adr_ex"},   32'(rd_adr_ex),   32'(e.rd));
        chk({tag, " imm_ex"},      imm_ex,           e.imm);
        chk({tag, " cmd"},         32'(dut_cmd()),   32'(e.cmd));
        chk({tag, " stall_ld_ex"}, 32'(stall_ld_ex), 32'(e.sld));
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t = $signed(v << (32 - bits));
        return 32'(t >>> (32 - bits));
    endfunction

    function automatic logic [10:0] ill_cmd();
`ifdef ID_ILLEGAL_TRAP_EN
        return 11'h400;
`else
        return 11'h000;
`endif
    endfunction

    function automatic ex_t decode(input logic [31:0] i, input logic [29:0] pc);
        ex_t e;
        e = '{valid: 1'b1, pc: pc, inst: i, rd: 5'd0, imm: 32'd0, cmd: 11'd0, sld: 1'b0};
        case (i[6:0])
            7'h33: begin e.cmd = 11'h001; e.rd = i[11:7]; end
            7'h13: begin e.cmd = 11'h001; e.rd = i[11:7]; e.imm = sext(32'(i[31:20]), 12); end
            7'h03: begin e.cmd = 11'h002; e.rd = i[11:7]; e.imm = sext(32'(i[31:20]), 12); end
            7'h23: begin e.cmd = 11'h004; e.imm = sext(32'({i[31:25], i[11:7]}), 12); end
            7'h63: begin e.cmd = 11'h008;
                         e.imm = sext(32'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13); end
            7'h6F: begin e.cmd = 11'h010; e.rd = i[11:7];
                         e.imm = sext(32'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21); end
            7'h67: begin e.cmd = 11'h020; e.rd = i[11:7]; e.imm = sext(32'(i[31:20]), 12); end
            7'h37: begin e.cmd = 11'h040; e.rd = i[11:7]; e.imm = {i[31:12], 12'h000}; end
            7'h17: begin e.cmd = 11'h080; e.rd = i[11:7]; e.imm = {i[31:12], 12'h000}; end
            7'h73: begin
                if (i == 32'h0000_0073)      e.cmd = 11'h100;
                else if (i == 32'h3020_0073) e.cmd = 11'h200;
                else                         e.cmd = ill_cmd();
            end
            default: e.cmd = ill_cmd();
        endcase
        return e;
    endfunction

    function automatic logic model_sld(input ex_t cur, input logic [31:0] i);
        logic u1, u2;
        u1 = (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
        u2 = (i[6:0] inside {7'h33, 7'h23, 7'h63});
        return cur.valid && cur.cmd[1] && cur.rd != 5'd0 &&
               ((u1 && i[19:15] == cur.rd) || (u2 && i[24:20] == cur.rd));
    endfunction

    function automatic ex_t bubble(input logic [29:0] pc, input logic sld);
        return '{valid: 1'b0, pc: pc, inst: NOP, rd: 5'd0, imm: 32'd0, cmd: 11'd0, sld: sld};
    endfunction

    function automatic ex_t model_next(input ex_t cur, input logic [31:0] i, input logic [29:0] pc,
                                       input logic st, input logic rp, input logic start,
                                       input logic sld);
        if (rp)          return bubble(cur.pc, 1'b0);
        else if (st)     return cur;
        else if (sld)    return bubble(pc, 1'b1);
        else if (!start) return bubble(pc, 1'b0);
        else             return decode(i, pc);
    endfunction

    // ---------------- test ----------------
    vec_t vt[12];
    ex_t  rst_val, cur, nxt;
    logic [6:0] ops[10];

    initial begin
        rst_val = bubble(30'd0, 1'b0);
        vt[0]  = '{32'h00A00093, 30'h10, 11'h001, 5'd1, 32'h0000000A};
        vt[1]  = '{32'hFE000EE3, 30'h11, 11'h008, 5'd0, 32'hFFFFFFFC};
        vt[2]  = '{32'hFE20AC23, 30'h12, 11'h004, 5'd0, 32'hFFFFFFF8};
        vt[3]  = '{32'h0000A283, 30'h13, 11'h002, 5'd5, 32'h00000000};
        vt[4]  = '{32'h123451B7, 30'h14, 11'h040, 5'd3, 32'h12345000};
        vt[5]  = '{32'h008000EF, 30'h15, 11'h010, 5'd1, 32'h00000008};
        vt[6]  = '{32'hFFF10067, 30'h16, 11'h020, 5'd0, 32'hFFFFFFFF};
        vt[7]  = '{32'h00001297, 30'h17, 11'h080, 5'd5, 32'h00001000};
        vt[8]  = '{32'h00000073, 30'h18, 11'h100, 5'd0, 32'h00000000};
        vt[9]  = '{32'h30200073, 30'h19, 11'h200, 5'd0, 32'h00000000};
        vt[10] = '{32'h00228333, 30'h1A, 11'h001, 5'd6, 32'h00000000};
        vt[11] = '{32'hFFFFFFFF, 30'h1B, ill_cmd(), 5'd0, 32'h00000000};
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

        inst_id = NOP; pc_id = '0; stall = 0; rst_pipe = 0; cpu_start = 1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #6 check_ex("reset", rst_val);
        chk("reset stall_ld", 32'(stall_ld), 32'd0);
        #3 rst_n = 1'b1;

        // decode table
        foreach (vt[k]) begin
            inst_id = vt[k].inst; pc_id = vt[k].pc;
            #1;
            chk($sformatf("vec%0d rs1_adr_id", k), 32'(rs1_adr_id), 32'(vt[k].inst[19:15]));
            chk($sformatf("vec%0d rs2_adr_id", k), 32'(rs2_adr_id), 32'(vt[k].inst[24:20]));
            tick();
            check_ex($sformatf("vec%0d", k),
                     '{valid: 1'b1, pc: vt[k].pc, inst: vt[k].inst, rd: vt[k].rd,
                       imm: vt[k].imm, cmd: vt[k].cmd, sld: 1'b0});
        end

        // load-use: lw x5,0(x1) then add x6,x5,x2
        inst_id = 32'h0000A283; pc_id = 30'h40;
        tick();
        inst_id = 32'h00228333; pc_id = 30'h41;
        #1 chk("lu stall_ld", 32'(stall_ld), 32'd1);
        tick();
        check_ex("lu bubble", bubble(30'h41, 1'b1));
        chk("lu stall_ld after bubble", 32'(stall_ld), 32'd0);
        tick();
        check_ex("lu issue", decode(32'h00228333, 30'h41));

        // rst_pipe beats stall
        inst_id = 32'h00A00093; pc_id = 30'h20;
        tick();
        inst_id = 32'h123451B7; pc_id = 30'h21; stall = 1; rst_pipe = 1;
        tick();
        check_ex("flush+stall", bubble(30'h20, 1'b0));
        stall = 0; rst_pipe = 0; inst_id = 32'h00A00093; pc_id = 30'h24;
        tick();
        stall = 1; inst_id = 32'h123451B7; pc_id = 30'h28;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_ex($sformatf("hold%0d", c), decode(32'h00A00093, 30'h24));
        end
        stall = 0;

        // cpu_start low forces bubbles
        cpu_start = 0; inst_id = 32'h00A00093; pc_id = 30'h30;
        tick();
        check_ex("nostart", bubble(30'h30, 1'b0));
        cpu_start = 1;
        tick();
        check_ex("start", decode(32'h00A00093, 30'h30));

        // async reset mid-stream, no clock edge before the check
        inst_id = 32'h0000A283; pc_id = 30'h50;
        tick();
        rst_n = 1'b0;
        #2 check_ex("async reset", rst_val);
        inst_id = 32'h00228333;
        #1 chk("reset stall_ld", 32'(stall_ld), 32'd0);
        rst_n = 1'b1;

        // randomized traffic vs model
        cur = rst_val;
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [31:0] ins;
            logic s_exp;
            r = int'($urandom_range(0, 11));
            ins = $urandom;
            if (r < 10) begin
                ins[6:0]   = ops[r];
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                if (ops[r] == 7'h73) begin
                    case ($urandom_range(0, 2))
                        0: ins = 32'h0000_0073;
                        1: ins = 32'h3020_0073;
                        default: ;
                    endcase
                end
            end
            inst_id   = ins;
            pc_id     = 30'($urandom);
            stall     = ($urandom_range(0, 99) < 15);
            rst_pipe  = ($urandom_range(0, 99) < 8);
            cpu_start = ($urandom_range(0, 99) >= 5);
            #1;
            s_exp = model_sld(cur, ins);
            chk("rnd stall_ld", 32'(stall_ld), 32'(s_exp));
            nxt = model_next(cur, ins, pc_id, stall, rst_pipe, cpu_start, s_exp);
            tick();
            check_ex("rnd", nxt);
            cur = nxt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
